// File: rtl/vrf_wb_arbiter.sv
// vrf_wb_arbiter: round-robin write-back arbiter for the two VRF write ports,
// plus an optional busy[] scoreboard for RAW/WAW stalls at vector issue.
// Optional feature macro: VRF_WB_SCOREBOARD_EN (defined -> scoreboard built,
// undefined -> iss_ok tied high and iss_* ignored).
module vrf_wb_arbiter #(
  parameter int NREQ        = 4,
  parameter int XLEN_VEC    = 128,
  parameter int RFIDX_WIDTH = 5,
  parameter int RFREG_NUM   = 2**RFIDX_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*RFIDX_WIDTH-1:0]   req_addr,
  input  logic [NREQ*XLEN_VEC-1:0]      req_data,
  output logic [1:0]                    vwe,
  output logic [RFIDX_WIDTH-1:0]        va5,
  output logic [RFIDX_WIDTH-1:0]        va6,
  output logic [XLEN_VEC-1:0]           vwd1,
  output logic [XLEN_VEC-1:0]           vwd2,
  input  logic                          iss_valid,
  input  logic [RFIDX_WIDTH-1:0]        iss_rd,
  input  logic [RFIDX_WIDTH-1:0]        iss_rs1,
  input  logic [RFIDX_WIDTH-1:0]        iss_rs2,
  output logic                          iss_ok
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [RFIDX_WIDTH-1:0] addr_a [NREQ];
  logic [XLEN_VEC-1:0]    data_a [NREQ];

  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                   g0_vld, g1_vld;
  logic [PW-1:0]          g0_idx, g1_idx;
  logic [RFIDX_WIDTH-1:0] g0_addr, g1_addr;

  logic [1:0]             vwe_q, vwe_d;
  logic [RFIDX_WIDTH-1:0] va5_q, va5_d, va6_q, va6_d;
  logic [XLEN_VEC-1:0]    vwd1_q, vwd1_d, vwd2_q, vwd2_d;

  // Unpack the flat requester buses into per-requester arrays
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i] = req_addr[i*RFIDX_WIDTH +: RFIDX_WIDTH];
      data_a[i] = req_data[i*XLEN_VEC +: XLEN_VEC];
    end
  end

  // Scan requesters from rr_ptr: first valid -> port 0, next non-conflicting -> port 1
  always_comb begin
    int               j;
    logic [PW-1:0]    jx;
    req_ready = '0;
    g0_vld    = 1'b0;
    g1_vld    = 1'b0;
    g0_idx    = '0;
    g1_idx    = '0;
    g0_addr   = '0;
    g1_addr   = '0;
    j         = 0;
    jx        = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      jx = PW'(j);
      if (req_valid[jx]) begin
        if (!g0_vld) begin
          g0_vld        = 1'b1;
          g0_idx        = jx;
          g0_addr       = addr_a[jx];
          req_ready[jx] = 1'b1;
        end else if (!g1_vld &&
                     !((addr_a[jx] != '0) && (addr_a[jx] == g0_addr))) begin
          // Two writes to the same real register in one cycle would race in
          // the VRF, so the second one waits; register 0 writes are dropped
          // anyway and need no such protection.
          g1_vld        = 1'b1;
          g1_idx        = jx;
          g1_addr       = addr_a[jx];
          req_ready[jx] = 1'b1;
        end
      end
    end
  end

  // Next round-robin pointer and next write-port contents
  always_comb begin
    int nxt;
    if (g1_vld)      nxt = int'(g1_idx) + 1;
    else if (g0_vld) nxt = int'(g0_idx) + 1;
    else             nxt = int'(rr_ptr_q);
    if (nxt >= NREQ) nxt = 0;
    rr_ptr_d = PW'(nxt);

    // Register-0 writes complete the handshake but never reach the VRF
    vwe_d  = {g1_vld && (g1_addr != '0), g0_vld && (g0_addr != '0)};
    va5_d  = g0_vld ? g0_addr         : va5_q;
    vwd1_d = g0_vld ? data_a[g0_idx]  : vwd1_q;
    va6_d  = g1_vld ? g1_addr         : va6_q;
    vwd2_d = g1_vld ? data_a[g1_idx]  : vwd2_q;
  end

  // Pointer and VRF write-port registers; reset drops any in-flight write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      vwe_q    <= '0;
      va5_q    <= '0;
      va6_q    <= '0;
      vwd1_q   <= '0;
      vwd2_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      vwe_q    <= vwe_d;
      va5_q    <= va5_d;
      va6_q    <= va6_d;
      vwd1_q   <= vwd1_d;
      vwd2_q   <= vwd2_d;
    end
  end

  assign vwe  = vwe_q;
  assign va5  = va5_q;
  assign va6  = va6_q;
  assign vwd1 = vwd1_q;
  assign vwd2 = vwd2_q;

`ifdef VRF_WB_SCOREBOARD_EN
  logic [RFREG_NUM-1:0] busy_q, busy_d;

  assign iss_ok = !busy_q[iss_rs1] && !busy_q[iss_rs2] && !busy_q[iss_rd];

  // Clear on committed write-back, then set on issue so a same-cycle set wins
  always_comb begin
    busy_d = busy_q;
    if (vwe_q[0]) busy_d[va5_q] = 1'b0;
    if (vwe_q[1]) busy_d[va6_q] = 1'b0;
    if (iss_valid && iss_ok && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end
`else
  // Without the scoreboard the issue stage is never stalled from here
  logic unused_iss;
  assign unused_iss = ^{iss_valid, iss_rd, iss_rs1, iss_rs2, (RFREG_NUM > 0)};
  assign iss_ok     = 1'b1;
`endif

endmodule
